// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control FSM, memory port arbiter and memory.
// Holds the arbiter state encoding, the access-owner encoding and the default
// address/data widths of the unified memory.
package cpu_pkg;

  localparam int AW_DEFAULT = 8;
  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick (combinational).
//   req0        in  CPU request
//   req1        in  loader request
//   last_owner  in  owner of the previous access (OWN_CPU / OWN_LDR)
//   grant_valid out at least one request present
//   grant_id    out requester picked (OWN_CPU / OWN_LDR)
module rr_arb2
  import cpu_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = OWN_CPU;
    if (req0 && req1) begin
      // tie goes to whoever did not own the last access
      grant_id = (last_owner == OWN_CPU) ? OWN_LDR : OWN_CPU;
    end else if (req1) begin
      grant_id = OWN_LDR;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between the CPU control path and the
// program-loader/debug port using a req/ack handshake, round-robin arbitration
// and a configurable read latency.
//   clk, rst_n                          clock, async active-low reset
//   cpu_req/we/addr/wdata, cpu_ack/rdata CPU port
//   ldr_req/we/addr/wdata, ldr_ack/rdata loader port
//   mem_en/we/addr/wdata, mem_rdata      memory macro interface
//   busy                                 high whenever not IDLE
//   owner                                owner of current/last access (0 CPU, 1 loader)
//
// state | meaning
// IDLE  | waiting for a request; grants and latches fields
// ISSUE | one-cycle mem_en strobe
// WAIT  | read latency countdown, address held
// DONE  | one-cycle ack to owner, read data valid
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int AW     = AW_DEFAULT,
  parameter int DW     = DW_DEFAULT,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  output logic [DW-1:0] ldr_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_rd_lat_check
    $error("mem_port_arbiter: RD_LAT must be in 1..4, got %0d", RD_LAT);
  end

  localparam logic       RD_SINGLE = (RD_LAT == 1);
  localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

  arb_state_t state;
  logic [1:0] wait_cnt;
  logic       grant_valid;
  logic       grant_id;
  logic       to_done;

  rr_arb2 u_rr_arb2 (
    .req0        (cpu_req),
    .req1        (ldr_req),
    .last_owner  (owner),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // mem_we/mem_addr/mem_wdata double as the latched request fields, so the
  // address stays stable through WAIT without extra registers.
  always_comb begin
    to_done = 1'b0;
    case (state)
      ISSUE:   to_done = mem_we || RD_SINGLE;
      WAIT:    to_done = (wait_cnt == 2'd1);
      default: to_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_LDR;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      ldr_ack   <= 1'b0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else begin
      mem_en  <= 1'b0;
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner     <= grant_id;
            mem_en    <= 1'b1;
            mem_we    <= (grant_id == OWN_LDR) ? ldr_we    : cpu_we;
            mem_addr  <= (grant_id == OWN_LDR) ? ldr_addr  : cpu_addr;
            mem_wdata <= (grant_id == OWN_LDR) ? ldr_wdata : cpu_wdata;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!to_done) begin
            wait_cnt <= WAIT_LOAD;
            state    <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 2'd1;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // read data is captured on the edge entering DONE, into the owner's
      // register only
      if (to_done) begin
        state   <= DONE;
        cpu_ack <= (owner == OWN_CPU);
        ldr_ack <= (owner == OWN_LDR);
        if (!mem_we) begin
          if (owner == OWN_CPU) cpu_rdata <= mem_rdata;
          else                  ldr_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Instance 0 uses RD_LAT = 1, instance 1 uses
// RD_LAT = 3. Each has its own memory model; a transaction-level reference
// (ref_mem, hold_*, last_own) predicts service order, ack cycle and read data.
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          cpu_req [2];
  logic          cpu_we [2];
  logic [AW-1:0] cpu_addr [2];
  logic [DW-1:0] cpu_wdata [2];
  logic          cpu_ack [2];
  logic [DW-1:0] cpu_rdata [2];
  logic          ldr_req [2];
  logic          ldr_we [2];
  logic [AW-1:0] ldr_addr [2];
  logic [DW-1:0] ldr_wdata [2];
  logic          ldr_ack [2];
  logic [DW-1:0] ldr_rdata [2];
  logic          mem_en [2];
  logic          mem_we [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic          busy [2];
  logic          owner [2];

  int nvec = 0;
  int nerr = 0;

  logic [7:0] mem [2][256];
  logic [7:0] ref_mem [2][256];
  logic [7:0] rd_addr [2];
  int         k [2] = '{100, 100};
  bit         loaded = 1'b0;

  int         last_own [2];
  logic [7:0] hold_c [2];
  logic [7:0] hold_l [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT((g == 0) ? 1 : 3)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (cpu_req[g]),
      .cpu_we    (cpu_we[g]),
      .cpu_addr  (cpu_addr[g]),
      .cpu_wdata (cpu_wdata[g]),
      .cpu_ack   (cpu_ack[g]),
      .cpu_rdata (cpu_rdata[g]),
      .ldr_req   (ldr_req[g]),
      .ldr_we    (ldr_we[g]),
      .ldr_addr  (ldr_addr[g]),
      .ldr_wdata (ldr_wdata[g]),
      .ldr_ack   (ldr_ack[g]),
      .ldr_rdata (ldr_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g]),
      .owner     (owner[g])
    );
  end

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] init_val(input int a);
    case (a)
      'h10:    return 8'hA5;
      'h05:    return 8'h7E;
      'h30:    return 8'h11;
      'h31:    return 8'h22;
      default: return 8'(a * 37 + 11);
    endcase
  endfunction

  // Memory macro model: data is valid only in the cycle whose closing edge is
  // RD_LAT-1 cycles after the mem_en cycle; junk otherwise.
  always @(negedge clk) begin
    if (!loaded) begin
      for (int d = 0; d < 2; d++)
        for (int a = 0; a < 256; a++) mem[d][a] <= init_val(a);
      loaded <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (mem_en[d]) begin
          k[d]       <= 0;
          rd_addr[d] <= mem_addr[d];
          if (mem_we[d]) mem[d][mem_addr[d]] <= mem_wdata[d];
          mem_rdata[d] <= (lat(d) == 1) ? mem[d][mem_addr[d]] : 8'($urandom);
        end else begin
          if (k[d] < 100) k[d] <= k[d] + 1;
          mem_rdata[d] <= (k[d] + 1 == lat(d) - 1) ? mem[d][rd_addr[d]] : 8'($urandom);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      cpu_req[d] = 1'b0; cpu_we[d] = 1'b0; cpu_addr[d] = '0; cpu_wdata[d] = '0;
      ldr_req[d] = 1'b0; ldr_we[d] = 1'b0; ldr_addr[d] = '0; ldr_wdata[d] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if ({busy[d], owner[d], cpu_ack[d], ldr_ack[d], mem_en[d], mem_we[d]} !== 6'b010000) begin
        $display("FAIL reset_ctrl dut=%0d got=%b exp=010000", d,
                 {busy[d], owner[d], cpu_ack[d], ldr_ack[d], mem_en[d], mem_we[d]});
        nerr++;
      end
      nvec++;
      if ({mem_addr[d], mem_wdata[d], cpu_rdata[d], ldr_rdata[d]} !== 32'h0) begin
        $display("FAIL reset_data dut=%0d got=%h exp=00000000", d,
                 {mem_addr[d], mem_wdata[d], cpu_rdata[d], ldr_rdata[d]});
        nerr++;
      end
    end
  endtask

  task automatic test_cpu_read();
    cpu_we[0] = 1'b0; cpu_addr[0] = 8'h10; cpu_wdata[0] = 8'($urandom); cpu_req[0] = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick();
      nvec++;
      if ({mem_en[0], cpu_ack[0], ldr_ack[0]} !== {cyc == 1, cyc == 2, 1'b0}) begin
        $display("FAIL cpu_read_seq cyc=%0d got=%b exp=%b", cyc,
                 {mem_en[0], cpu_ack[0], ldr_ack[0]}, {cyc == 1, cyc == 2, 1'b0});
        nerr++;
      end
      if (cyc == 1) begin
        nvec++;
        if ({mem_we[0], mem_addr[0]} !== {1'b0, 8'h10}) begin
          $display("FAIL cpu_read_addr got=%h exp=010", {mem_we[0], mem_addr[0]});
          nerr++;
        end
      end
      if (cyc == 2) begin
        nvec++;
        if ({cpu_rdata[0], owner[0]} !== {8'hA5, 1'b0}) begin
          $display("FAIL cpu_read_data got=%h/%b exp=a5/0", cpu_rdata[0], owner[0]);
          nerr++;
        end
      end
      if (cpu_ack[0]) cpu_req[0] = 1'b0;
    end
    cpu_req[0] = 1'b0;
  endtask

  task automatic test_ldr_write();
    ldr_we[0] = 1'b1; ldr_addr[0] = 8'h20; ldr_wdata[0] = 8'h3C; ldr_req[0] = 1'b1;
    ref_mem[0][8'h20] = 8'h3C;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      tick();
      nvec++;
      if ({mem_en[0], ldr_ack[0], cpu_ack[0]} !== {cyc == 1, cyc == 2, 1'b0}) begin
        $display("FAIL ldr_write_seq cyc=%0d got=%b exp=%b", cyc,
                 {mem_en[0], ldr_ack[0], cpu_ack[0]}, {cyc == 1, cyc == 2, 1'b0});
        nerr++;
      end
      if (cyc == 1) begin
        nvec++;
        if ({mem_we[0], mem_addr[0], mem_wdata[0]} !== {1'b1, 8'h20, 8'h3C}) begin
          $display("FAIL ldr_write_bus got=%h exp=1203c", {mem_we[0], mem_addr[0], mem_wdata[0]});
          nerr++;
        end
      end
      if (ldr_ack[0]) ldr_req[0] = 1'b0;
    end
    ldr_req[0] = 1'b0;
    cpu_we[0] = 1'b0; cpu_addr[0] = 8'h20; cpu_req[0] = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      tick();
      nvec++;
      if (cpu_ack[0] !== (cyc == 2) || (cyc == 2 && cpu_rdata[0] !== 8'h3C)) begin
        $display("FAIL readback cyc=%0d ack=%b rdata=%h exp_ack=%b exp_rdata=3c", cyc,
                 cpu_ack[0], cpu_rdata[0], cyc == 2);
        nerr++;
      end
      if (cpu_ack[0]) cpu_req[0] = 1'b0;
    end
    cpu_req[0] = 1'b0;
  endtask

  task automatic test_alternate();
    do_reset();
    cpu_we[0] = 1'b0; cpu_addr[0] = 8'h10; cpu_req[0] = 1'b1;
    ldr_we[0] = 1'b0; ldr_addr[0] = 8'h20; ldr_req[0] = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      nvec++;
      if ({busy[0], mem_en[0], cpu_ack[0], ldr_ack[0]} !==
          {cyc % 3 != 0, cyc % 3 == 1, cyc == 2 || cyc == 8, cyc == 5 || cyc == 11}) begin
        $display("FAIL alternate_seq cyc=%0d got=%b exp=%b", cyc,
                 {busy[0], mem_en[0], cpu_ack[0], ldr_ack[0]},
                 {cyc % 3 != 0, cyc % 3 == 1, cyc == 2 || cyc == 8, cyc == 5 || cyc == 11});
        nerr++;
      end
      if (cyc == 2 || cyc == 5) begin
        nvec++;
        if ((cyc == 2 && {owner[0], cpu_rdata[0]} !== {1'b0, 8'hA5}) ||
            (cyc == 5 && {owner[0], ldr_rdata[0]} !== {1'b1, 8'h3C})) begin
          $display("FAIL alternate_data cyc=%0d owner=%b cpu=%h ldr=%h exp owner/data per order",
                   cyc, owner[0], cpu_rdata[0], ldr_rdata[0]);
          nerr++;
        end
      end
      if (cyc == 11) begin
        cpu_req[0] = 1'b0;
        ldr_req[0] = 1'b0;
      end
    end
    cpu_req[0] = 1'b0; ldr_req[0] = 1'b0;
  endtask

  task automatic test_rd_lat3();
    cpu_we[1] = 1'b0; cpu_addr[1] = 8'h05; cpu_req[1] = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      nvec++;
      if ({busy[1], mem_en[1], cpu_ack[1], ldr_ack[1]} !== {cyc <= 4, cyc == 1, cyc == 4, 1'b0}) begin
        $display("FAIL lat3_seq cyc=%0d got=%b exp=%b", cyc,
                 {busy[1], mem_en[1], cpu_ack[1], ldr_ack[1]}, {cyc <= 4, cyc == 1, cyc == 4, 1'b0});
        nerr++;
      end
      if (cyc <= 4) begin
        nvec++;
        if (mem_addr[1] !== 8'h05 || (cyc == 4 && cpu_rdata[1] !== 8'h7E)) begin
          $display("FAIL lat3_data cyc=%0d addr=%h rdata=%h exp=05/7e", cyc, mem_addr[1], cpu_rdata[1]);
          nerr++;
        end
      end
      // request withdrawn before ack: access must still complete
      if (cyc == 1) cpu_req[1] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    cpu_we[1] = 1'b0; cpu_addr[1] = 8'h05; cpu_req[1] = 1'b1;
    tick();
    tick();
    nvec++;
    if (busy[1] !== 1'b1) begin
      $display("FAIL rstmid_busy_before got=%b exp=1", busy[1]);
      nerr++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({busy[1], cpu_ack[1], mem_en[1], owner[1]} !== 4'b0001) begin
      $display("FAIL rstmid_async got=%b exp=0001", {busy[1], cpu_ack[1], mem_en[1], owner[1]});
      nerr++;
    end
    cpu_req[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      nvec++;
      if ({busy[1], cpu_ack[1], ldr_ack[1]} !== 3'b000) begin
        $display("FAIL rstmid_quiet cyc=%0d got=%b exp=000", cyc, {busy[1], cpu_ack[1], ldr_ack[1]});
        nerr++;
      end
    end
    cpu_we[1] = 1'b0; cpu_addr[1] = 8'h05; cpu_req[1] = 1'b1;
    ldr_we[1] = 1'b0; ldr_addr[1] = 8'h06; ldr_req[1] = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      nvec++;
      if ({cpu_ack[1], ldr_ack[1]} !== {cyc == 4, cyc == 9} ||
          (cyc == 4 && cpu_rdata[1] !== 8'h7E) || (cyc == 9 && ldr_rdata[1] !== init_val(6))) begin
        $display("FAIL rstmid_tie cyc=%0d acks=%b exp=%b cpu=%h ldr=%h", cyc,
                 {cpu_ack[1], ldr_ack[1]}, {cyc == 4, cyc == 9}, cpu_rdata[1], ldr_rdata[1]);
        nerr++;
      end
      if (cpu_ack[1]) cpu_req[1] = 1'b0;
      if (ldr_ack[1]) ldr_req[1] = 1'b0;
    end
    cpu_req[1] = 1'b0; ldr_req[1] = 1'b0;
  endtask

  task automatic test_no_cross();
    ldr_we[0] = 1'b0; ldr_addr[0] = 8'h30; ldr_req[0] = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      tick();
      nvec++;
      if (ldr_ack[0] !== (cyc == 2) || (cyc == 2 && {ldr_rdata[0], cpu_rdata[0]} !== 16'h1100)) begin
        $display("FAIL nocross_ldr cyc=%0d ack=%b ldr=%h cpu=%h exp=11/00", cyc,
                 ldr_ack[0], ldr_rdata[0], cpu_rdata[0]);
        nerr++;
      end
      if (ldr_ack[0]) ldr_req[0] = 1'b0;
    end
    ldr_req[0] = 1'b0;
    cpu_we[0] = 1'b0; cpu_addr[0] = 8'h31; cpu_req[0] = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      tick();
      nvec++;
      if (cpu_ack[0] !== (cyc == 2) || (cyc >= 2 && {cpu_rdata[0], ldr_rdata[0]} !== 16'h2211)) begin
        $display("FAIL nocross_cpu cyc=%0d ack=%b cpu=%h ldr=%h exp=22/11", cyc,
                 cpu_ack[0], cpu_rdata[0], ldr_rdata[0]);
        nerr++;
      end
      if (cpu_ack[0]) cpu_req[0] = 1'b0;
    end
    cpu_req[0] = 1'b0;
  endtask

  task automatic rand_round(input int d);
    int         pick, first, t, exp_c, exp_l, n_acc, n_men, p;
    logic       we [2];
    logic [7:0] ad [2];
    logic [7:0] wd [2];
    bit         want [2];
    bit         got_c, got_l;
    pick = $urandom_range(0, 3);
    want[0] = (pick != 1);
    want[1] = (pick != 0);
    for (int q = 0; q < 2; q++) begin
      we[q] = 1'($urandom);
      ad[q] = 8'($urandom_range(0, 15));
      wd[q] = 8'($urandom);
    end
    cpu_we[d] = we[0]; cpu_addr[d] = ad[0]; cpu_wdata[d] = wd[0]; cpu_req[d] = want[0];
    ldr_we[d] = we[1]; ldr_addr[d] = ad[1]; ldr_wdata[d] = wd[1]; ldr_req[d] = want[1];
    // reference: serve in round-robin order, each access takes its latency
    // plus one idle cycle before the next grant
    exp_c = -1; exp_l = -1; t = 0; n_acc = 0;
    first = (want[0] && want[1]) ? 1 - last_own[d] : (want[0] ? 0 : 1);
    for (int n = 0; n < 2; n++) begin
      p = (n == 0) ? first : 1 - first;
      if (want[p]) begin
        t += we[p] ? 2 : 1 + lat(d);
        if (p == 0) exp_c = t; else exp_l = t;
        if (we[p])       ref_mem[d][ad[p]] = wd[p];
        else if (p == 0) hold_c[d] = ref_mem[d][ad[p]];
        else             hold_l[d] = ref_mem[d][ad[p]];
        last_own[d] = p;
        n_acc++;
        t += 1;
      end
    end
    got_c = !want[0]; got_l = !want[1]; n_men = 0;
    for (int cyc = 1; cyc <= 30 && !(got_c && got_l); cyc++) begin
      tick();
      if (mem_en[d]) n_men++;
      if (cpu_ack[d]) begin
        nvec++;
        if (cyc != exp_c || cpu_rdata[d] !== hold_c[d]) begin
          $display("FAIL rand_cpu_ack dut=%0d cyc=%0d exp_cyc=%0d rdata=%h exp=%h",
                   d, cyc, exp_c, cpu_rdata[d], hold_c[d]);
          nerr++;
        end
        cpu_req[d] = 1'b0;
        got_c = 1'b1;
      end
      if (ldr_ack[d]) begin
        nvec++;
        if (cyc != exp_l || ldr_rdata[d] !== hold_l[d]) begin
          $display("FAIL rand_ldr_ack dut=%0d cyc=%0d exp_cyc=%0d rdata=%h exp=%h",
                   d, cyc, exp_l, ldr_rdata[d], hold_l[d]);
          nerr++;
        end
        ldr_req[d] = 1'b0;
        got_l = 1'b1;
      end
    end
    nvec++;
    if (!(got_c && got_l)) begin
      $display("FAIL rand_timeout dut=%0d got_cpu=%b got_ldr=%b exp=11", d, got_c, got_l);
      nerr++;
    end
    cpu_req[d] = 1'b0; ldr_req[d] = 1'b0;
    tick();
    nvec++;
    if ({busy[d], cpu_rdata[d], ldr_rdata[d]} !== {1'b0, hold_c[d], hold_l[d]} || n_men != n_acc) begin
      $display("FAIL rand_end dut=%0d busy=%b cpu=%h ldr=%h strobes=%0d exp 0/%h/%h/%0d",
               d, busy[d], cpu_rdata[d], ldr_rdata[d], n_men, hold_c[d], hold_l[d], n_acc);
      nerr++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      last_own[d] = 1;
      hold_c[d]   = 8'h00;
      hold_l[d]   = 8'h00;
    end
    for (int r = 0; r < 80; r++) rand_round(r % 2);
  endtask

  initial begin
    idle_inputs();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 256; a++) ref_mem[d][a] = init_val(a);
    test_reset();
    test_cpu_read();
    test_ldr_write();
    test_alternate();
    test_rd_lat3();
    test_reset_mid();
    test_no_cross();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
